// File: rtl/ysyx_23060332_ctrl.sv
// ysyx_23060332_ctrl: multi-cycle sequencing controller for the NPC core.
// Owns pc and the instruction latch, walks each instruction through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, drives the fetch and load/store
// handshakes, gates register-file writes to WB and halts on trap,
// misaligned next pc or a watchdog expiry while waiting for memory.
module ysyx_23060332_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst_o,
    output logic [31:0] pc,
    input  logic        dec_reg_wen,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_trap,
    input  logic [31:0] exu_next_pc,
    output logic        lsu_req_valid,
    input  logic        lsu_rsp_valid,
    output logic        rf_wen,
    output logic        halted,
    output logic        timeout,
    output logic        misalign,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    // Wait counter only needs to reach TIMEOUT-1 (TIMEOUT >= 2).
    localparam int            WW       = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);
    localparam logic [31:0]   NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e        state_q,    state_d;
    logic [31:0]   pc_q,       pc_d;
    logic [31:0]   inst_q,     inst_d;
    logic [WW-1:0] wait_q,     wait_d;
    logic [31:0]   cycle_q,    cycle_d;
    logic [31:0]   instret_q,  instret_d;
    logic          halted_q,   halted_d;
    logic          timeout_q,  timeout_d;
    logic          misalign_q, misalign_d;

    logic          npc_aligned_s;

    assign npc_aligned_s = (exu_next_pc[1:0] == 2'b00);

    // Next-state and datapath-register update rules for every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        wait_d     = wait_q;
        instret_d  = instret_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        misalign_d = misalign_q;

        case (state_q)
            S_FETCH: begin
                if (ifu_rsp_valid) begin
                    // A response in the watchdog's last cycle still wins.
                    inst_d  = ifu_rsp_inst;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_MAX) begin
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_DECODE: begin
                if (dec_trap) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_is_load || dec_is_store) begin
                    wait_d  = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_rsp_valid) begin
                    wait_d  = '0;
                    state_d = S_WB;
                end else if (wait_q == WAIT_MAX) begin
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_WB: begin
                if (npc_aligned_s) begin
                    pc_d      = exu_next_pc;
                    instret_d = instret_q + 32'd1;
                    wait_d    = '0;
                    state_d   = S_FETCH;
                end else begin
                    // Misaligned target: keep pc at the faulting instruction.
                    misalign_d = 1'b1;
                    halted_d   = 1'b1;
                    state_d    = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Unreachable encoding: park safely.
                halted_d = 1'b1;
                state_d  = S_HALT;
            end
        endcase
    end

    // Cycle counter runs in every non-halted cycle and wraps naturally.
    always_comb begin
        if (state_q != S_HALT) begin
            cycle_d = cycle_q + 32'd1;
        end else begin
            cycle_d = cycle_q;
        end
    end

    // Single state register bank: all controller state moves on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            wait_q     <= '0;
            cycle_q    <= 32'd0;
            instret_q  <= 32'd0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            wait_q     <= wait_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

    // Strobes decode from state; rst masks them since state_q reads FETCH in reset.
    assign ifu_req_valid = ~rst & (state_q == S_FETCH);
    assign lsu_req_valid = ~rst & (state_q == S_MEM);
    assign rf_wen        = ~rst & (state_q == S_WB) & npc_aligned_s
                           & dec_reg_wen & ~dec_is_store;

    assign ifu_req_addr = pc_q;
    assign pc           = pc_q;
    assign inst_o       = inst_q;
    assign cycle_cnt    = cycle_q;
    assign instret      = instret_q;
    assign halted       = halted_q;
    assign timeout      = timeout_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_ysyx_23060332_ctrl.sv
// Self-checking bench for ysyx_23060332_ctrl. The bench plays IFU/IDU/EXU/LSU
// and predicts each instruction's outcome (cycle count, strobe counts, pc,
// counters, halt flags) from per-instruction arithmetic.
module tb_ysyx_23060332_ctrl;

    localparam int          TO   = 8;
    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_inst  = 32'd0;
    logic [31:0] inst_o;
    logic [31:0] pc;
    logic        dec_reg_wen   = 1'b0;
    logic        dec_is_load   = 1'b0;
    logic        dec_is_store  = 1'b0;
    logic        dec_trap      = 1'b0;
    logic [31:0] exu_next_pc   = 32'd0;
    logic        lsu_req_valid;
    logic        lsu_rsp_valid = 1'b0;
    logic        rf_wen;
    logic        halted;
    logic        timeout;
    logic        misalign;
    logic [31:0] cycle_cnt;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    // Reference model state (instruction-level view).
    logic [31:0] m_pc, m_inst, m_cycle, m_instret;
    logic        m_halted, m_timeout, m_misalign;

    ysyx_23060332_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .inst_o(inst_o), .pc(pc),
        .dec_reg_wen(dec_reg_wen), .dec_is_load(dec_is_load),
        .dec_is_store(dec_is_store), .dec_trap(dec_trap),
        .exu_next_pc(exu_next_pc),
        .lsu_req_valid(lsu_req_valid), .lsu_rsp_valid(lsu_rsp_valid),
        .rf_wen(rf_wen), .halted(halted), .timeout(timeout), .misalign(misalign),
        .cycle_cnt(cycle_cnt), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic post_checks();
        chk("pc",       pc,        m_pc);
        chk("inst_o",   inst_o,    m_inst);
        chk("instret",  instret,   m_instret);
        chk("cycle",    cycle_cnt, m_cycle);
        chk("halted",   {31'd0, halted},   {31'd0, m_halted});
        chk("timeout",  {31'd0, timeout},  {31'd0, m_timeout});
        chk("misalign", {31'd0, misalign}, {31'd0, m_misalign});
        chk("ifu_req",  {31'd0, ifu_req_valid}, {31'd0, ~m_halted});
        if (!m_halted) chk("ifu_addr", ifu_req_addr, m_pc);
        else           chk("ifu_addr_h", ifu_req_addr, m_pc);
    endtask

    // Reset pulse with checks while asserted and after release; ends at a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0;
        dec_trap = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0; dec_reg_wen = 1'b0;
        #1;
        chk("rst_ifu_req", {31'd0, ifu_req_valid}, 32'd0);
        chk("rst_lsu_req", {31'd0, lsu_req_valid}, 32'd0);
        chk("rst_rf_wen",  {31'd0, rf_wen},        32'd0);
        chk("rst_pc",      pc,        RPC);
        chk("rst_inst",    inst_o,    NOP);
        chk("rst_cycle",   cycle_cnt, 32'd0);
        step();
        rst = 1'b0;
        m_pc = RPC; m_inst = NOP; m_cycle = 0; m_instret = 0;
        m_halted = 1'b0; m_timeout = 1'b0; m_misalign = 1'b0;
        #1;
        post_checks();
    endtask

    // One instruction. kind: 0 alu/jump, 1 load, 2 store. fd/md: wait cycles
    // before the fetch/mem response (>= TO means no response).
    task automatic run_inst(input int kind, input int fd, input int md, input logic rw,
                            input logic trap, input logic [31:0] npc, input logic [31:0] word);
        int   exp_cyc, exp_f, exp_l, exp_w, seen_f, seen_l, seen_w;
        logic mem, mis, to_f, to_m, retire;
        mem  = (kind != 0);
        mis  = (npc[1:0] != 2'b00);
        to_f = (fd >= TO);
        to_m = !to_f && !trap && mem && (md >= TO);
        if (to_f)       exp_cyc = TO;
        else if (trap)  exp_cyc = fd + 2;
        else if (to_m)  exp_cyc = fd + 3 + TO;
        else            exp_cyc = fd + 4 + (mem ? md + 1 : 0);
        exp_f  = to_f ? TO : fd + 1;
        exp_l  = (to_f || trap || !mem) ? 0 : (to_m ? TO : md + 1);
        retire = !to_f && !trap && !to_m && !mis;
        exp_w  = (retire && rw && kind != 2) ? 1 : 0;

        dec_is_load = (kind == 1); dec_is_store = (kind == 2);
        dec_reg_wen = rw; dec_trap = trap; exu_next_pc = npc; ifu_rsp_inst = word;
        seen_f = 0; seen_l = 0; seen_w = 0;
        for (int c = 0; c < exp_cyc; c++) begin
            if (ifu_req_valid) begin
                seen_f++;
                chk("fetch_addr", ifu_req_addr, m_pc);
            end
            if (lsu_req_valid) seen_l++;
            if (rf_wen) seen_w++;
            ifu_rsp_valid = ifu_req_valid && (seen_f == fd + 1);
            lsu_rsp_valid = lsu_req_valid && (seen_l == md + 1);
            step();
        end
        ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0;

        m_cycle = m_cycle + exp_cyc;
        if (!to_f) m_inst = word;
        if (retire) begin
            m_pc = npc;
            m_instret = m_instret + 1;
        end else begin
            m_halted = 1'b1;
            if (to_f || to_m) m_timeout = 1'b1;
            else if (!trap)   m_misalign = 1'b1;
        end
        chk("n_fetch", seen_f, exp_f);
        chk("n_lsu",   seen_l, exp_l);
        chk("n_rfwen", seen_w, exp_w);
        post_checks();
    endtask

    // Idle while halted: nothing may move.
    task automatic idle_halted(input int n);
        for (int c = 0; c < n; c++) begin
            ifu_rsp_valid = 1'b1; lsu_rsp_valid = 1'b1;
            step();
            chk("h_rfwen", {31'd0, rf_wen},        32'd0);
            chk("h_lsu",   {31'd0, lsu_req_valid}, 32'd0);
        end
        ifu_rsp_valid = 1'b0; lsu_rsp_valid = 1'b0;
        post_checks();
    endtask

    initial begin
        do_reset();

        // addi stream with immediate responses, then a delayed store.
        run_inst(0, 0, 0, 1'b1, 1'b0, m_pc + 32'd4, ADDI);
        run_inst(0, 0, 0, 1'b1, 1'b0, m_pc + 32'd4, ADDI);
        run_inst(2, 0, 3, 1'b1, 1'b0, m_pc + 32'd4, 32'h00a12023);
        // Boundary: responses in the last watchdog cycle.
        run_inst(1, TO - 1, TO - 1, 1'b1, 1'b0, m_pc + 32'd4, 32'h00012083);

        // Randomized instruction mix.
        for (int i = 0; i < 40; i++) begin
            int          k, f, md;
            logic [31:0] np;
            k  = $urandom_range(2, 0);
            f  = $urandom_range(TO - 1, 0);
            md = $urandom_range(TO - 1, 0);
            if ($urandom_range(3, 0) == 0) np = $urandom() & 32'hFFFF_FFFC;
            else                           np = m_pc + 32'd4;
            run_inst(k, f, md, 1'($urandom_range(1, 0)), 1'b0, np, $urandom());
        end
        run_inst(0, 1, 0, 1'b1, 1'b1, m_pc + 32'd4, 32'h00100073);
        idle_halted(5);

        // Misaligned jump target halts with pc unchanged.
        do_reset();
        run_inst(0, 0, 0, 1'b1, 1'b0, 32'h8000_0102, 32'h1020006f);
        idle_halted(3);

        // Fetch watchdog, then load/store watchdog.
        do_reset();
        run_inst(0, TO + 5, 0, 1'b1, 1'b0, m_pc + 32'd4, ADDI);
        idle_halted(3);
        do_reset();
        run_inst(2, 2, TO + 5, 1'b0, 1'b0, m_pc + 32'd4, 32'h00a12023);
        idle_halted(3);

        // Trap on the third instruction.
        do_reset();
        run_inst(0, 0, 0, 1'b1, 1'b0, m_pc + 32'd4, ADDI);
        run_inst(1, 1, 2, 1'b1, 1'b0, m_pc + 32'd4, 32'h00012083);
        run_inst(0, 0, 0, 1'b0, 1'b1, m_pc + 32'd4, 32'h00100073);
        chk("trap_instret", instret, 32'd2);
        idle_halted(4);

        // Reset while in MEM, stale lsu response ignored in FETCH afterwards.
        do_reset();
        dec_is_store = 1'b1; dec_is_load = 1'b0; dec_trap = 1'b0; dec_reg_wen = 1'b0;
        exu_next_pc = RPC + 32'd4; ifu_rsp_inst = 32'h00a12023;
        ifu_rsp_valid = 1'b1;
        step();
        ifu_rsp_valid = 1'b0;
        step();
        step();
        chk("mem_lsu_req", {31'd0, lsu_req_valid}, 32'd1);
        rst = 1'b1; lsu_rsp_valid = 1'b1;
        #1;
        chk("abort_lsu",   {31'd0, lsu_req_valid}, 32'd0);
        chk("abort_rfwen", {31'd0, rf_wen},        32'd0);
        chk("abort_pc",    pc,        RPC);
        chk("abort_cycle", cycle_cnt, 32'd0);
        chk("abort_iret",  instret,   32'd0);
        step();
        rst = 1'b0;
        m_pc = RPC; m_inst = NOP; m_cycle = 0; m_instret = 0;
        m_halted = 1'b0; m_timeout = 1'b0; m_misalign = 1'b0;
        step();
        lsu_rsp_valid = 1'b0;
        m_cycle = m_cycle + 1;
        post_checks();
        run_inst(0, 2, 0, 1'b1, 1'b0, m_pc + 32'd4, ADDI);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
